// File: rtl/if_fetch.sv
// if_fetch: the instruction-fetch stage. It owns the PC, keeps at most one
// request outstanding on an SRAM-like instruction bus, and offers each fetched
// instruction, together with its PC-derived words, to the IF/ID register.
// Branch redirects take effect after the delay slot. Flush redirects take
// effect immediately and cancel any fetch that is in flight.
//
// Ports
//   _clk, _rst            clock; synchronous active-high reset
//   _stall                IF/ID is holding, so an offered instruction is not consumed
//   _flush, _flush_pc     redirect to _flush_pc (highest priority)
//   _br_taken, _br_target taken branch/jump from ID (one-cycle pulse)
//   inst_req_, inst_addr_ bus request and address
//   _inst_addr_ok         request accepted
//   _inst_data_ok, _inst_rdata  read data return
//   valid_, inst_, pc_    offered instruction and its PC (0 when !valid_)
//   pc_sub4_/pc_add4_/pc_add8_  pc_-4, pc_+4, pc_+8
//   exc_                  bit0 = fetch address error (AdEL)
//   jb_delaysolt_         bit0 = the offered instruction is a branch delay slot
//
// Configuration macro IF_ADDR_CHECK_EN: when defined, a misaligned pc issues no
// bus request and offers a faulting slot instead. When undefined, the address
// is forced word-aligned and exc_ stays 0.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        _clk,
  input  logic        _rst,
  input  logic        _stall,
  input  logic        _flush,
  input  logic [31:0] _flush_pc,
  input  logic        _br_taken,
  input  logic [31:0] _br_target,
  output logic        inst_req_,
  output logic [31:0] inst_addr_,
  input  logic        _inst_addr_ok,
  input  logic        _inst_data_ok,
  input  logic [31:0] _inst_rdata,
  output logic        valid_,
  output logic [31:0] inst_,
  output logic [31:0] pc_,
  output logic [31:0] pc_sub4_,
  output logic [31:0] pc_add8_,
  output logic [31:0] pc_add4_,
  output logic [31:0] exc_,
  output logic [31:0] jb_delaysolt_
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} st_t;

  st_t         st, st_nx;
  logic [31:0] pc, br_tgt, hold_inst, npc;
  logic        br_pend, cancel;
  logic        misal, acc, offer, hand, dslot;

`ifdef IF_ADDR_CHECK_EN
  logic hold_exc;
  assign misal = |pc[1:0];
`else
  assign misal = 1'b0;
`endif

  // state register
  always_ff @(posedge _clk) begin
    if (_rst) st <= S_IDLE;
    else      st <= st_nx;
  end

  // next state
  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE: st_nx = S_REQ;
      S_REQ: begin
        // an accepted request cannot be taken back, so a flush in the
        // accept cycle still waits for (and then drops) its data
        if (_flush)     st_nx = acc ? S_WAIT : S_REQ;
        else if (misal) st_nx = S_HOLD;
        else if (acc)   st_nx = S_WAIT;
      end
      S_WAIT: begin
        if (_inst_data_ok)
          st_nx = (_flush || cancel || !_stall) ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (_flush || !_stall) st_nx = S_REQ;
      end
    endcase
  end

  // outputs
  always_comb begin
    inst_req_     = 1'b0;
    offer         = 1'b0;
    inst_         = '0;
    pc_           = '0;
    pc_sub4_      = '0;
    pc_add4_      = '0;
    pc_add8_      = '0;
    exc_          = '0;
    jb_delaysolt_ = '0;
    unique case (st)
      S_REQ:  inst_req_ = !misal;
      S_WAIT: offer     = _inst_data_ok && !cancel;
      S_HOLD: offer     = 1'b1;
      default: ;
    endcase
    acc   = inst_req_ && _inst_addr_ok;
    hand  = offer && !_stall && !_flush;
    // a branch seen in the hand-off cycle itself already makes this the slot
    dslot = br_pend || _br_taken;
    npc   = dslot ? (_br_taken ? _br_target : br_tgt) : pc + 32'd4;
    valid_ = offer;
`ifdef IF_ADDR_CHECK_EN
    inst_addr_ = inst_req_ ? pc : '0;
`else
    inst_addr_ = inst_req_ ? {pc[31:2], 2'b00} : '0;
`endif
    if (offer) begin
      inst_            = (st == S_HOLD) ? hold_inst : _inst_rdata;
      pc_              = pc;
      pc_sub4_         = pc - 32'd4;
      pc_add4_         = pc + 32'd4;
      pc_add8_         = pc + 32'd8;
      jb_delaysolt_[0] = dslot;
`ifdef IF_ADDR_CHECK_EN
      exc_[0]          = (st == S_HOLD) && hold_exc;
`endif
    end
  end

  // PC, branch and cancel bookkeeping, held instruction
  always_ff @(posedge _clk) begin
    if (_rst) begin
      pc        <= RESET_PC;
      br_tgt    <= '0;
      br_pend   <= 1'b0;
      cancel    <= 1'b0;
      hold_inst <= '0;
`ifdef IF_ADDR_CHECK_EN
      hold_exc  <= 1'b0;
`endif
    end else begin
      if (_flush) begin
        pc      <= _flush_pc;
        br_pend <= 1'b0;
      end else if (hand) begin
        pc      <= npc;
        br_pend <= 1'b0;
      end else if (_br_taken) begin
        br_pend <= 1'b1;
        br_tgt  <= _br_target;
      end

      if (st == S_WAIT && _inst_data_ok)
        cancel <= 1'b0;
      else if (_flush && (st == S_WAIT || (st == S_REQ && acc)))
        cancel <= 1'b1;

      if (st == S_WAIT && _inst_data_ok) begin
        hold_inst <= _inst_rdata;
`ifdef IF_ADDR_CHECK_EN
        hold_exc  <= 1'b0;
`endif
      end else if (st == S_REQ && misal) begin
        hold_inst <= '0;
`ifdef IF_ADDR_CHECK_EN
        hold_exc  <= 1'b1;
`endif
      end
    end
  end

endmodule
